decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  Y86-64 pipeline decode stage; sits directly downstream of fetch and consumes its 145-bit decode_reg bundle.
//  Owns the F->D pipeline register, the 15x64 register file and the D->E pipeline register.
//  Resolves srcA/srcB/dstE/dstM and forwards valA/valB from the E, M and W stages.
//  Flags load/use hazards to pipeline control and drives the 217-bit execute_reg bundle.
// PARAMETERS
//  RSP_ID     4      register index of %rsp
//  RNONE      4'hF   "no register" encoding
//  NOP_ICODE  4'h1   icode inserted on a bubble
// PORTS
//  clk          in   1    rising-edge clock
//  rst_n        in   1    asynchronous active-low reset
//  decode_reg   in   145  [144]stat [143:140]icode [139:136]ifun [135:132]rA [131:128]rB [127:64]valC [63:0]valP
//  D_stall      in   1    hold the D register
//  D_bubble     in   1    load a nop into the D register
//  E_bubble     in   1    load a nop into the E register (execute_reg)
//  e_dstE       in   4    execute-stage destE;  e_valE   in 64  its ALU result
//  M_dstE       in   4    memory-stage dstE;    M_valE   in 64
//  M_dstM       in   4    memory-stage dstM;    m_valM   in 64  load data
//  W_dstE       in   4    writeback dstE;       W_valE   in 64  (register file write port E)
//  W_dstM       in   4    writeback dstM;       W_valM   in 64  (register file write port M)
//  execute_reg  out  217  [216]stat [215:212]icode [211:208]ifun [207:144]valC [143:80]valA [79:16]valB [15:12]dstE [11:8]dstM [7:4]srcA [3:0]srcB
//  load_use     out  1    comb: E icode is 5 (mrmovq) or 11 (popq) and E dstM != RNONE and equals d_srcA or d_srcB
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): all 15 registers = 0; D register = nop (stat=1, icode=NOP_ICODE, ifun=0, rA=rB=RNONE, valC=valP=0);
//   execute_reg = nop bundle (stat=1, icode=1, all other fields 0, dst/src fields = RNONE); load_use = 0.
//  D register on posedge: D_stall -> hold; else D_bubble -> nop; else load decode_reg. D_stall takes priority over D_bubble.
//  Comb decode from D register (d_ signals):
//   srcA = rA for icode 2,4,6,10; RSP_ID for 9,11; else RNONE.
//   srcB = rB for icode 4,5,6; RSP_ID for 8,9,10,11; else RNONE.
//   dstE = rB for icode 2,3,6; RSP_ID for 8,9,10,11; else RNONE (cmov condition is resolved in execute).
//   dstM = rA for icode 5,11; else RNONE.
//  valA select, first match wins: icode 7 or 8 -> valP; srcA==RNONE -> 0; e_dstE; M_dstM (m_valM); M_dstE (M_valE);
//   W_dstM (W_valM); W_dstE (W_valE); else register file. valB: same chain without the valP term.
//  Register file: 2 comb read ports, 2 write ports on posedge; RNONE writes ignored;
//   W_dstE==W_dstM -> W_valM wins. A same-cycle read returns the old value (W forwarding covers it).
//  E register on posedge: E_bubble -> nop bundle; else load {D stat, icode, ifun, valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB}.
//   The E register is never stalled. Latency is 1 cycle decode_reg -> D register and 1 cycle D register -> execute_reg.
//  load_use is computed from execute_reg[215:212] and [11:8] against the current d_srcA/d_srcB.
//   Control is expected to answer with D_stall=1, E_bubble=1.
//  Reset mid-operation: in-flight D and E contents are discarded and the register file is cleared; no partial writes.
//  stat is passed through unmodified; decode never raises an exception.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> execute_reg icode=1, dstE=dstM=srcA=srcB=F immediately; all regs read 0.
//  2 irmovq (icode 3, rB=2, valC=0x55): after 2 clk, execute_reg dstE=2, srcA=srcB=F, valC=0x55.
//    Next cycle drive W_dstE=2, W_valE=0x55 -> a later rrmovq rA=2 reads valA=0x55 from the register file.
//  3 Forward priority: with D=addq rA=3, drive e_dstE=3/0x11, M_dstE=3/0x22, W_dstE=3/0x33 -> valA=0x11.
//    Remove e_dstE -> 0x22; remove M_dstE -> 0x33.
//  4 Load/use: execute_reg holds mrmovq dstM=5 while D holds addq rA=5 -> load_use=1.
//    Apply D_stall+E_bubble -> D held, E=nop. Next cycle load_use=0.
//  5 Stack ops: D=pushq rA=1 -> srcA=1, srcB=4, dstE=4. D=ret -> srcA=srcB=4, dstE=4, dstM=F.
//    D=call valP=0x20 -> valA=0x20.
//  6 Dual write: W_dstE=W_dstM=6, W_valE=1, W_valM=2 -> reg 6 reads 2. W_dstE=F -> no register changes.

Source files
------------

// File: rtl/decode_stage.sv
// Y86-64 decode stage: F->D register, 15x64 register file, operand forwarding
// from E/M/W, load/use hazard detection and the D->E pipeline register.
module decode_stage #(
  parameter logic [3:0] RSP_ID    = 4'd4,
  parameter logic [3:0] RNONE     = 4'hF,
  parameter logic [3:0] NOP_ICODE = 4'h1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [144:0] decode_reg,
  input  logic         D_stall,
  input  logic         D_bubble,
  input  logic         E_bubble,
  input  logic [3:0]   e_dstE,
  input  logic [63:0]  e_valE,
  input  logic [3:0]   M_dstE,
  input  logic [63:0]  M_valE,
  input  logic [3:0]   M_dstM,
  input  logic [63:0]  m_valM,
  input  logic [3:0]   W_dstE,
  input  logic [63:0]  W_valE,
  input  logic [3:0]   W_dstM,
  input  logic [63:0]  W_valM,
  output logic [216:0] execute_reg,
  output logic         load_use
);

  localparam logic [144:0] D_NOP = {1'b1, NOP_ICODE, 4'h0, RNONE, RNONE, 64'd0, 64'd0};
  localparam logic [216:0] E_NOP = {1'b1, NOP_ICODE, 4'h0, 192'd0, RNONE, RNONE, RNONE, RNONE};

  logic [144:0] d_q, d_d;
  logic [216:0] e_q, e_d;
  logic [63:0]  rf_q [0:14];

  logic [3:0]  d_icode, d_ifun, d_ra, d_rb;
  logic [63:0] d_valc, d_valp;
  logic [3:0]  d_srca, d_srcb, d_dste, d_dstm;
  logic [63:0] d_vala, d_valb;

  assign d_icode = d_q[143:140];
  assign d_ifun  = d_q[139:136];
  assign d_ra    = d_q[135:132];
  assign d_rb    = d_q[131:128];
  assign d_valc  = d_q[127:64];
  assign d_valp  = d_q[63:0];

  always_comb begin
    d_d = d_q;
    if (!D_stall) begin
      d_d = D_bubble ? D_NOP : decode_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= D_NOP;
    end else begin
      d_q <= d_d;
    end
  end

  always_comb begin
    d_srca = RNONE;
    d_srcb = RNONE;
    d_dste = RNONE;
    d_dstm = RNONE;
    case (d_icode)
      4'h2, 4'h4, 4'h6, 4'hA: d_srca = d_ra;
      4'h9, 4'hB:             d_srca = RSP_ID;
      default:                d_srca = RNONE;
    endcase
    case (d_icode)
      4'h4, 4'h5, 4'h6:       d_srcb = d_rb;
      4'h8, 4'h9, 4'hA, 4'hB: d_srcb = RSP_ID;
      default:                d_srcb = RNONE;
    endcase
    case (d_icode)
      4'h2, 4'h3, 4'h6:       d_dste = d_rb;
      4'h8, 4'h9, 4'hA, 4'hB: d_dste = RSP_ID;
      default:                d_dste = RNONE;
    endcase
    case (d_icode)
      4'h5, 4'hB: d_dstm = d_ra;
      default:    d_dstm = RNONE;
    endcase
  end

  // Nearest producer wins; the register file is the last resort and never sees RNONE.
  function automatic logic [63:0] fwd_val(input logic [3:0] src);
    if (src == RNONE)       return 64'd0;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rf_q[src];
  endfunction

  always_comb begin
    d_vala = fwd_val(d_srca);
    d_valb = fwd_val(d_srcb);
    if (d_icode == 4'h7 || d_icode == 4'h8) begin
      d_vala = d_valp;
    end
  end

  // Port M is written after port E so a shared destination keeps the load value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        rf_q[i] <= 64'd0;
      end
    end else begin
      if (W_dstE != RNONE) rf_q[W_dstE] <= W_valE;
      if (W_dstM != RNONE) rf_q[W_dstM] <= W_valM;
    end
  end

  always_comb begin
    e_d = {d_q[144], d_icode, d_ifun, d_valc, d_vala, d_valb, d_dste, d_dstm, d_srca, d_srcb};
    if (E_bubble) begin
      e_d = E_NOP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= E_NOP;
    end else begin
      e_q <= e_d;
    end
  end

  assign execute_reg = e_q;

  always_comb begin
    load_use = 1'b0;
    if ((e_q[215:212] == 4'h5 || e_q[215:212] == 4'hB) && e_q[11:8] != RNONE &&
        (e_q[11:8] == d_srca || e_q[11:8] == d_srcb)) begin
      load_use = 1'b1;
    end
  end

endmodule
